// File: rtl/reed_conditioner.sv
// Reed-contact conditioner: synchronises and debounces the raw contact, emits one
// pulse per accepted closure, measures the closure-to-closure period and flags a stopped wheel.
module reed_conditioner #(
  parameter int unsigned DEBOUNCE = 16,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_reed_raw,
  output logic        o_reed,
  output logic [15:0] o_period,
  output logic        o_period_valid,
  output logic        o_stopped
);

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_CLOSING = 2'd1,
    ST_CLOSED  = 2'd2,
    ST_OPENING = 2'd3
  } state_t;

  localparam logic [7:0]  DEB_LIMIT  = 8'(DEBOUNCE);
  localparam logic [15:0] TIMEOUT_M1 = TIMEOUT - 16'd1;

  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_reed;
  logic [15:0] r_interval;
  logic [15:0] r_period;
  logic        r_period_valid;
  logic        r_stopped;
  logic        w_close;

  // Closure accepted on this edge: the same edge that raises the reed pulse.
  assign w_close = (r_state == ST_CLOSING) && r_sync2 && (r_cnt == DEB_LIMIT);

  // Two-flop synchroniser for the asynchronous contact input.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_reed_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with the registered closure pulse.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_OPEN;
      r_cnt   <= 8'd0;
      r_reed  <= 1'b0;
    end else begin
      r_reed <= 1'b0;
      case (r_state)
        ST_OPEN: begin
          if (r_sync2) begin
            r_state <= ST_CLOSING;
            r_cnt   <= 8'd1;
          end else begin
            r_cnt <= 8'd0;
          end
        end
        ST_CLOSING: begin
          if (!r_sync2) begin
            r_state <= ST_OPEN;
            r_cnt   <= 8'd0;
          end else if (r_cnt == DEB_LIMIT) begin
            r_state <= ST_CLOSED;
            r_cnt   <= 8'd0;
            r_reed  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_CLOSED: begin
          if (!r_sync2) begin
            r_state <= ST_OPENING;
            r_cnt   <= 8'd1;
          end else begin
            r_cnt <= 8'd0;
          end
        end
        ST_OPENING: begin
          if (r_sync2) begin
            r_state <= ST_CLOSED;
            r_cnt   <= 8'd0;
          end else if (r_cnt == DEB_LIMIT) begin
            r_state <= ST_OPEN;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_OPEN;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Interval counter, period capture and stopped flag; a closure beats a coincident timeout.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_interval     <= 16'd0;
      r_period       <= 16'd0;
      r_period_valid <= 1'b0;
      r_stopped      <= 1'b1;
    end else begin
      r_period_valid <= 1'b0;
      if (w_close) begin
        r_interval <= 16'd1;
        if (!r_stopped) begin
          r_period       <= r_interval;
          r_period_valid <= 1'b1;
        end
      end else if (r_interval != 16'hFFFF) begin
        r_interval <= r_interval + 16'd1;
      end

      if (r_reed) begin
        r_stopped <= 1'b0;
      end else if (!w_close && (r_interval == TIMEOUT_M1)) begin
        r_stopped <= 1'b1;
      end
    end
  end

  assign o_reed         = r_reed;
  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;
  assign o_stopped      = r_stopped;

endmodule

// File: tb/tb_reed_conditioner.sv
// Directed bench for reed_conditioner with DEBOUNCE=4, TIMEOUT=1000.
module tb_reed_conditioner;

  logic        clk;
  logic        rst;
  logic        raw;
  logic        reed;
  logic [15:0] period;
  logic        period_valid;
  logic        stopped;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  typedef struct {
    logic        raw;
    logic        reed;
    logic        pv;
    logic        stopped;
    logic [15:0] period;
  } vec_t;

  vec_t vecs [24];

  reed_conditioner #(.DEBOUNCE(4), .TIMEOUT(16'd1000)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_reed_raw    (raw),
    .o_reed        (reed),
    .o_period      (period),
    .o_period_valid(period_valid),
    .o_stopped     (stopped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
    end
  endtask

  initial begin
    int n_reed;
    int n_pv;
    int e;
    logic [7:0] pat;

    // Power-on case: raw closes at edge 10, first pulse expected at edge 16.
    for (int i = 0; i < 24; i++) begin
      e = i + 1;
      vecs[i].raw     = (e >= 10);
      vecs[i].reed    = (e == 16);
      vecs[i].pv      = 1'b0;
      vecs[i].stopped = (e <= 16);
      vecs[i].period  = 16'd0;
    end

    rst = 1'b1;
    raw = 1'b0;
    #2;
    chk("rst_reed", 16'(reed), 16'd0);
    chk("rst_pv", 16'(period_valid), 16'd0);
    chk("rst_stopped", 16'(stopped), 16'd1);
    chk("rst_period", period, 16'd0);
    #21;
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      raw = vecs[i].raw;
      tick();
      chk("tab_reed", 16'(reed), 16'(vecs[i].reed));
      chk("tab_pv", 16'(period_valid), 16'(vecs[i].pv));
      chk("tab_stopped", 16'(stopped), 16'(vecs[i].stopped));
      chk("tab_period", period, vecs[i].period);
    end

    // Second closure at edge 516 (period 500), held with a 2-cycle glitch.
    n_reed = 0;
    n_pv   = 0;
    for (int k = 25; k <= 560; k++) begin
      raw = (k >= 510) && (k <= 529) && (k != 520) && (k != 521);
      tick();
      if (reed) n_reed++;
      if (period_valid) n_pv++;
      if (k == 515) chk("c2_early", 16'(reed), 16'd0);
      if (k == 516) begin
        chk("c2_reed", 16'(reed), 16'd1);
        chk("c2_pv", 16'(period_valid), 16'd1);
        chk("c2_period", period, 16'd500);
        chk("c2_stopped", 16'(stopped), 16'd0);
      end
      if (k == 517) chk("c2_pv_drop", 16'(period_valid), 16'd0);
    end
    chk("glitch_pulses", 16'(n_reed), 16'd1);
    chk("glitch_pv", 16'(n_pv), 16'd1);
    chk("glitch_stopped", 16'(stopped), 16'd0);

    // Short 3-cycle closure with release bounce, then a clean closure from OPEN.
    pat = 8'b0101_0111;
    n_reed = 0;
    for (int k = 561; k <= 640; k++) begin
      if (k >= 600 && k <= 607) raw = pat[k - 600];
      else raw = (k >= 620) && (k < 640);
      tick();
      if (k <= 625 && reed) n_reed++;
      if (k == 619) chk("short_period", period, 16'd500);
      if (k == 626) begin
        chk("c3_reed", 16'(reed), 16'd1);
        chk("c3_pv", 16'(period_valid), 16'd1);
        chk("c3_period", period, 16'd110);
      end
    end
    chk("short_pulses", 16'(n_reed), 16'd0);

    // Timeout: stopped sets at edge 1625; next closure gives no period update.
    n_reed = 0;
    for (int k = 641; k <= 1720; k++) begin
      raw = (k >= 1700);
      tick();
      if (k <= 1705 && reed) n_reed++;
      if (k == 1624) chk("to_before", 16'(stopped), 16'd0);
      if (k == 1625) chk("to_set", 16'(stopped), 16'd1);
      if (k == 1706) begin
        chk("to_reed", 16'(reed), 16'd1);
        chk("to_pv", 16'(period_valid), 16'd0);
        chk("to_period", period, 16'd110);
        chk("to_stopped_hold", 16'(stopped), 16'd1);
      end
      if (k == 1707) chk("to_cleared", 16'(stopped), 16'd0);
    end
    chk("to_no_pulse", 16'(n_reed), 16'd0);

    // Asynchronous reset while CLOSED with the contact still held.
    #3;
    rst = 1'b1;
    #1;
    chk("ar_reed", 16'(reed), 16'd0);
    chk("ar_pv", 16'(period_valid), 16'd0);
    chk("ar_period", period, 16'd0);
    chk("ar_stopped", 16'(stopped), 16'd1);
    #1;
    rst = 1'b0;
    n_reed = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (reed) n_reed++;
      if (k == 6) chk("ar_early", 16'(reed), 16'd0);
      if (k == 7) begin
        chk("ar_reed_new", 16'(reed), 16'd1);
        chk("ar_pv_new", 16'(period_valid), 16'd0);
        chk("ar_period_new", period, 16'd0);
      end
    end
    chk("ar_pulses", 16'(n_reed), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reed_conditioner.md
REED_CONDITIONER -- requirements
Module: reed_conditioner

Interface
REQ-001 Parameter DEBOUNCE, default 16: consecutive clock cycles a changed contact level must persist before it is accepted (range 1..255).
REQ-002 Parameter TIMEOUT, default 16'd50000: clock cycles without an accepted closure before the wheel is declared stopped (range 2..65535).
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-005 reed_raw  input  1  raw reed-contact level, asynchronous to clock; 1 = contact closed.
REQ-006 reed  output  1  one-cycle pulse per accepted (debounced) contact closure; drives the distance/speed counters' reed input.
REQ-007 period  output  16  clock cycles between the two most recent accepted closures, held between updates.
REQ-008 period_valid  output  1  one-cycle strobe, coincident with reed, when period has just been updated.
REQ-009 stopped  output  1  level; 1 = no accepted closure within TIMEOUT cycles, or none since reset.

Function
REQ-010 reed_raw SHALL pass through a two-flop synchronizer; only the second flop output (sync) SHALL feed any other logic.
REQ-011 Debounce FSM states SHALL be OPEN, CLOSING, CLOSED, OPENING; reset state OPEN.
REQ-012 OPEN: sync=1 -> CLOSING, debounce counter loaded to 1; else stay.
REQ-013 CLOSING: sync=0 -> OPEN, counter cleared; sync=1 and counter=DEBOUNCE -> CLOSED; else counter increments.
REQ-014 CLOSED: sync=0 -> OPENING, counter loaded to 1; else stay.
REQ-015 OPENING: sync=1 -> CLOSED, counter cleared; sync=0 and counter=DEBOUNCE -> OPEN; else counter increments.
REQ-016 reed SHALL be 1 for exactly the one cycle following the CLOSING->CLOSED transition edge; no pulse on opening, on aborted transitions, or while remaining CLOSED.
REQ-017 Latency: reed_raw first sampled 1 at edge k and held -> reed high in the cycle starting at edge k+DEBOUNCE+2.
REQ-018 A closure lasting fewer than DEBOUNCE synchronized cycles SHALL produce no pulse; a bounce during OPENING SHALL return to CLOSED without a new pulse.
REQ-019 Interval counter (16 bit): loads 1 on the edge where reed is asserted, else increments, saturating at 16'hFFFF (no wrap).
REQ-020 On a reed cycle with stopped=0: period <= interval counter value, period_valid=1; period therefore equals the cycle distance between consecutive reed pulses.
REQ-021 On a reed cycle with stopped=1: period unchanged, period_valid=0, stopped cleared on the following edge.
REQ-022 stopped SHALL set on the edge where interval counter reaches TIMEOUT with no reed in that cycle; if reed and timeout coincide, reed wins (stopped stays 0, period updated).
REQ-023 period_valid SHALL never assert without reed; reed SHALL never assert on two consecutive cycles.

Reset
REQ-024 Reset asserted: FSM=OPEN, synchronizer flops=0, debounce counter=0, interval counter=0, reed=0, period=0, period_valid=0, stopped=1.
REQ-025 Reset asserted mid-closure (CLOSING or CLOSED) SHALL discard it; after release a contact still closed is re-debounced from OPEN and yields one pulse after DEBOUNCE+2 cycles.

Verification (DEBOUNCE=4, TIMEOUT=1000)
REQ-026 Release reset, raw=1 from edge 10 held -> reed=1 only in cycle starting edge 16; period_valid=0; stopped 1->0 after that cycle.
REQ-027 Two clean closures with reed at edges 16 and 516 -> second reed has period_valid=1, period=500; stopped stays 0.
REQ-028 raw pulses high for 3 cycles, bounces 1-0-1 on release -> no reed, period unchanged, FSM back to OPEN.
REQ-029 Closure held 20 cycles with 2-cycle low glitch mid-closure -> exactly one reed pulse.
REQ-030 After a valid pulse, no closure for 1000 cycles -> stopped=1 on edge counter hits 1000; next closure -> reed=1, period_valid=0, period holds prior value.
REQ-031 Assert reset asynchronously between edges while CLOSED -> outputs per REQ-024 before next edge; raw still high -> one new pulse 6 cycles after release.
